// File: rtl/regfile_arbiter_pkg.sv
// Shared definitions for the two-requester register-file arbiter:
// default bus widths and the RUN/CLEAR controller state encoding.
package regfile_arbiter_pkg;

  localparam int DW_DEFAULT = 8;
  localparam int AW_DEFAULT = 2;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: combinational one-hot grant, zero latency.
// On contention the pointer moves to the loser; otherwise it holds.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic rr_q, rr_d;

  always_comb begin
    gnt  = 2'b00;
    rr_d = rr_q;
    case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
        gnt  = rr_q ? 2'b10 : 2'b01;
        rr_d = ~rr_q;
      end
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Arbitrates two requesters onto a single-port register file; grant and rf access are
// combinational, read data returns one cycle later. A clear sequence zeroes every entry.
module regfile_arbiter
  import regfile_arbiter_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req,
  input  logic [1:0]      we,
  input  logic [2*AW-1:0] addr,
  input  logic [2*DW-1:0] wdata,
  output logic [1:0]      gnt,
  output logic [1:0]      rvalid,
  output logic [DW-1:0]   rdata,
  input  logic            clr_start,
  output logic            clr_busy,
  output logic            rf_w_en,
  output logic [AW-1:0]   rf_w_addr,
  output logic [DW-1:0]   rf_w_data,
  output logic            rf_r_en,
  output logic [AW-1:0]   rf_r_addr,
  input  logic [DW-1:0]   rf_r_data
);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [1:0]    rvalid_q, rvalid_d;

  logic          run, clearing;
  logic [1:0]    req_run;
  logic          sel, sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // Qualifying with rst makes every combinational output drop the moment reset asserts.
  assign run      = rst && (state_q == ST_RUN);
  assign clearing = rst && (state_q == ST_CLEAR);
  assign req_run  = req & {2{run}};

  rr_arbiter_2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req_run),
    .gnt (gnt)
  );

  assign sel       = gnt[1];
  assign sel_we    = sel ? we[1] : we[0];
  assign sel_addr  = sel ? addr[AW +: AW] : addr[0 +: AW];
  assign sel_wdata = sel ? wdata[DW +: DW] : wdata[0 +: DW];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rvalid_d  = 2'b00;
    rf_w_en   = 1'b0;
    rf_w_addr = '0;
    rf_w_data = '0;
    rf_r_en   = 1'b0;
    rf_r_addr = '0;
    if (clearing) begin
      rf_w_en   = 1'b1;
      rf_w_addr = cnt_q;
      cnt_d     = cnt_q + AW'(1);
      if (&cnt_q) begin
        state_d = ST_RUN;
      end
    end else if (|gnt) begin
      if (sel_we) begin
        rf_w_en   = 1'b1;
        rf_w_addr = sel_addr;
        rf_w_data = sel_wdata;
      end else begin
        rf_r_en   = 1'b1;
        rf_r_addr = sel_addr;
        rvalid_d  = gnt;
      end
    end
    // The grant in this same cycle still completes; the clear starts on the next one.
    if (run && clr_start) begin
      state_d = ST_CLEAR;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      cnt_q    <= '0;
      rvalid_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rvalid   = rvalid_q;
  assign rdata    = (|rvalid_q) ? rf_r_data : '0;
  assign clr_busy = clearing;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: vector table, directed clear/reset sequences, random run vs model.
module tb_regfile_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req, we;
  logic [3:0] addr;
  logic [15:0] wdata;
  logic [1:0] gnt, rvalid;
  logic [7:0] rdata;
  logic       clr_start, clr_busy;
  logic       rf_w_en, rf_r_en;
  logic [1:0] rf_w_addr, rf_r_addr;
  logic [7:0] rf_w_data;
  logic [7:0] rf_r_data = 8'h00;
  logic [7:0] rf_mem [4] = '{default: 8'h00};

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .rf_w_en   (rf_w_en),
    .rf_w_addr (rf_w_addr),
    .rf_w_data (rf_w_data),
    .rf_r_en   (rf_r_en),
    .rf_r_addr (rf_r_addr),
    .rf_r_data (rf_r_data)
  );

  // External register file: not reset, registered read.
  always @(posedge clk) begin
    if (rf_w_en) rf_mem[rf_w_addr] <= rf_w_data;
    if (rf_r_en) rf_r_data <= rf_mem[rf_r_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [1:0] a0,
                       input logic [1:0] a1, input logic [7:0] d0, input logic [7:0] d1,
                       input logic c);
    req = r; we = w; addr = {a1, a0}; wdata = {d1, d0}; clr_start = c;
  endtask

  task automatic wr0(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    drive(2'b01, 2'b01, a, 2'b00, d, 8'h00, 1'b0);
    #1;
    chk($sformatf("wr%0d gnt", a), gnt, 2'b01);
    chk($sformatf("wr%0d w_en", a), rf_w_en, 1'b1);
    chk($sformatf("wr%0d w_addr", a), rf_w_addr, a);
    chk($sformatf("wr%0d w_data", a), rf_w_data, d);
  endtask

  task automatic rd0(input logic [1:0] a, input logic [7:0] exp);
    @(negedge clk);
    drive(2'b01, 2'b00, a, 2'b00, 8'h00, 8'h00, 1'b0);
    #1;
    chk($sformatf("rd%0d gnt", a), gnt, 2'b01);
    chk($sformatf("rd%0d r_en", a), rf_r_en, 1'b1);
    chk($sformatf("rd%0d r_addr", a), rf_r_addr, a);
    @(negedge clk);
    drive(2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0);
    #1;
    chk($sformatf("rd%0d rvalid", a), rvalid, 2'b01);
    chk($sformatf("rd%0d rdata", a), rdata, exp);
  endtask

  typedef struct {
    logic [1:0] req, we, a0, a1;
    logic [7:0] d0, d1;
    logic [1:0] gnt;
    logic       wen;
    logic [1:0] waddr;
    logic [7:0] wdata;
    logic       ren;
    logic [1:0] raddr;
    logic [1:0] rvalid;
    logic [7:0] rdata;
  } vec_t;

  vec_t tbl [10];

  typedef struct {
    bit         act;
    bit         w;
    logic [1:0] a;
    logic [7:0] d;
  } txn_t;

  txn_t       t [2];
  logic [7:0] gold [4];
  int         rr_m, clr_left, pend_rv, next_rv, win;
  logic [7:0] pend_rd;
  bit         both, clr;
  logic [1:0] e_gnt, e_waddr, e_raddr;
  logic [7:0] e_wdata;
  logic       e_wen, e_ren;

  initial begin
    //            req    we     a0     a1     d0     d1     gnt    wen   waddr  wdata  ren   raddr  rvalid rdata
    tbl[0] = '{2'b01, 2'b01, 2'd1, 2'd0, 8'hA5, 8'h00, 2'b01, 1'b1, 2'd1, 8'hA5, 1'b0, 2'd0, 2'b00, 8'h00};
    tbl[1] = '{2'b01, 2'b00, 2'd1, 2'd0, 8'h00, 8'h00, 2'b01, 1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 2'b00, 8'h00};
    tbl[2] = '{2'b00, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 2'b00, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'b01, 8'hA5};
    tbl[3] = '{2'b11, 2'b00, 2'd0, 2'd2, 8'h00, 8'h00, 2'b01, 1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 2'b00, 8'h00};
    tbl[4] = '{2'b11, 2'b00, 2'd0, 2'd2, 8'h00, 8'h00, 2'b10, 1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 2'b01, 8'h00};
    tbl[5] = '{2'b11, 2'b00, 2'd0, 2'd2, 8'h00, 8'h00, 2'b01, 1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 2'b10, 8'h00};
    tbl[6] = '{2'b11, 2'b00, 2'd0, 2'd2, 8'h00, 8'h00, 2'b10, 1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 2'b01, 8'h00};
    tbl[7] = '{2'b00, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 2'b00, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'b10, 8'h00};
    tbl[8] = '{2'b11, 2'b11, 2'd0, 2'd3, 8'h11, 8'h44, 2'b01, 1'b1, 2'd0, 8'h11, 1'b0, 2'd0, 2'b00, 8'h00};
    tbl[9] = '{2'b10, 2'b10, 2'd0, 2'd3, 8'h00, 8'h44, 2'b10, 1'b1, 2'd3, 8'h44, 1'b0, 2'd0, 2'b00, 8'h00};

    // Reset state, with requests already pending.
    rst = 1'b0;
    drive(2'b11, 2'b00, 2'd1, 2'd2, 8'h00, 8'h00, 1'b1);
    #2;
    chk("rst gnt", gnt, 2'b00);
    chk("rst rvalid", rvalid, 2'b00);
    chk("rst rdata", rdata, 8'h00);
    chk("rst clr_busy", clr_busy, 1'b0);
    chk("rst w_en", rf_w_en, 1'b0);
    chk("rst r_en", rf_r_en, 1'b0);
    chk("rst r_addr", rf_r_addr, 2'd0);
    @(negedge clk);
    drive(2'b00, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0);
    rst = 1'b1;

    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      drive(tbl[k].req, tbl[k].we, tbl[k].a0, tbl[k].a1, tbl[k].d0, tbl[k].d1, 1'b0);
      #1;
      chk($sformatf("vec%0d gnt", k), gnt, tbl[k].gnt);
      chk($sformatf("vec%0d w_en", k), rf_w_en, tbl[k].wen);
      chk($sformatf("vec%0d w_addr", k), rf_w_addr, tbl[k].waddr);
      chk($sformatf("vec%0d w_data", k), rf_w_data, tbl[k].wdata);
      chk($sformatf("vec%0d r_en", k), rf_r_en, tbl[k].ren);
      chk($sformatf("vec%0d r_addr", k), rf_r_addr, tbl[k].raddr);
      chk($sformatf("vec%0d rvalid", k), rvalid, tbl[k].rvalid);
      if (tbl[k].rvalid != 2'b00) chk($sformatf("vec%0d rdata", k), rdata, tbl[k].rdata);
    end

    // Full clear while both requesters are asking; a late clr_start must be ignored.
    for (int k = 0; k < 4; k++) wr0(2'(k), 8'(8'h11 * (k + 1)));
    @(negedge clk);
    drive(2'b00, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1);
    #1;
    chk("clr start busy", clr_busy, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(2'b11, 2'b00, 2'd1, 2'd2, 8'h00, 8'h00, (k == 3));
      #1;
      chk($sformatf("clr%0d busy", k), clr_busy, 1'b1);
      chk($sformatf("clr%0d gnt", k), gnt, 2'b00);
      chk($sformatf("clr%0d w_en", k), rf_w_en, 1'b1);
      chk($sformatf("clr%0d w_addr", k), rf_w_addr, k);
      chk($sformatf("clr%0d w_data", k), rf_w_data, 8'h00);
      chk($sformatf("clr%0d r_en", k), rf_r_en, 1'b0);
    end
    @(negedge clk);
    drive(2'b00, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0);
    #1;
    chk("clr done busy", clr_busy, 1'b0);
    for (int k = 0; k < 4; k++) rd0(2'(k), 8'h00);

    // Read granted with clr_start, then reset after address 1 has been cleared.
    for (int k = 0; k < 4; k++) wr0(2'(k), 8'(8'h11 * (k + 1)));
    @(negedge clk);
    drive(2'b01, 2'b00, 2'd3, 2'd0, 8'h00, 8'h00, 1'b1);
    #1;
    chk("rdclr gnt", gnt, 2'b01);
    chk("rdclr r_en", rf_r_en, 1'b1);
    chk("rdclr r_addr", rf_r_addr, 2'd3);
    @(negedge clk);
    drive(2'b11, 2'b00, 2'd1, 2'd2, 8'h00, 8'h00, 1'b0);
    #1;
    chk("rdclr c1 busy", clr_busy, 1'b1);
    chk("rdclr c1 rvalid", rvalid, 2'b01);
    chk("rdclr c1 rdata", rdata, 8'h44);
    chk("rdclr c1 w_addr", rf_w_addr, 2'd0);
    @(negedge clk);
    #1;
    chk("rdclr c2 w_addr", rf_w_addr, 2'd1);
    chk("rdclr c2 rvalid", rvalid, 2'b00);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midclr rst gnt", gnt, 2'b00);
    chk("midclr rst busy", clr_busy, 1'b0);
    chk("midclr rst w_en", rf_w_en, 1'b0);
    chk("midclr rst w_addr", rf_w_addr, 2'd0);
    chk("midclr rst w_data", rf_w_data, 8'h00);
    chk("midclr rst rvalid", rvalid, 2'b00);
    chk("midclr rst rdata", rdata, 8'h00);
    @(negedge clk);
    drive(2'b00, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0);
    rst = 1'b1;
    rd0(2'd0, 8'h00);
    rd0(2'd1, 8'h00);
    rd0(2'd2, 8'h33);
    rd0(2'd3, 8'h44);

    // Random traffic against a transaction-level model.
    gold[0] = 8'h00; gold[1] = 8'h00; gold[2] = 8'h33; gold[3] = 8'h44;
    rr_m = 0; clr_left = 0; pend_rv = 0; pend_rd = 8'h00;
    for (int i = 0; i < 2; i++) t[i] = '{act: 1'b0, w: 1'b0, a: 2'd0, d: 8'h00};
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!t[i].act && $urandom_range(1, 0) == 1) begin
          t[i].act = 1'b1;
          t[i].w   = 1'($urandom_range(1, 0));
          t[i].a   = 2'($urandom_range(3, 0));
          t[i].d   = 8'($urandom_range(255, 0));
        end
      end
      clr = ($urandom_range(15, 0) == 0);
      drive({t[1].act, t[0].act}, {t[1].w, t[0].w}, t[0].a, t[1].a, t[0].d, t[1].d, clr);
      #1;
      both = t[0].act && t[1].act;
      win = -1;
      if (clr_left == 0) begin
        if (both) win = rr_m;
        else if (t[0].act) win = 0;
        else if (t[1].act) win = 1;
      end
      e_gnt = 2'b00; e_wen = 1'b0; e_waddr = 2'd0; e_wdata = 8'h00; e_ren = 1'b0; e_raddr = 2'd0;
      if (clr_left > 0) begin
        e_wen = 1'b1; e_waddr = 2'(4 - clr_left);
      end else if (win >= 0) begin
        e_gnt = 2'(1 << win);
        if (t[win].w) begin
          e_wen = 1'b1; e_waddr = t[win].a; e_wdata = t[win].d;
        end else begin
          e_ren = 1'b1; e_raddr = t[win].a;
        end
      end
      chk("rand gnt", gnt, e_gnt);
      chk("rand busy", clr_busy, (clr_left > 0));
      chk("rand w_en", rf_w_en, e_wen);
      chk("rand w_addr", rf_w_addr, e_waddr);
      chk("rand w_data", rf_w_data, e_wdata);
      chk("rand r_en", rf_r_en, e_ren);
      chk("rand r_addr", rf_r_addr, e_raddr);
      chk("rand rvalid", rvalid, pend_rv);
      if (pend_rv != 0) chk("rand rdata", rdata, pend_rd);
      next_rv = 0;
      if (clr_left > 0) begin
        gold[4 - clr_left] = 8'h00;
        clr_left--;
      end else begin
        if (win >= 0) begin
          if (t[win].w) gold[t[win].a] = t[win].d;
          else begin
            next_rv = 1 << win;
            pend_rd = gold[t[win].a];
          end
          t[win].act = 1'b0;
          if (both) rr_m = 1 - win;
        end
        if (clr) clr_left = 4;
      end
      pend_rv = next_rv;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
